// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus words, RAM handshake state, and the
// memory arbiter's FSM and channel encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        FAULT  = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_chan_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request-unit and RAM-side signals of the memory arbiter.
// The slave view is the arbiter; the master view is its environment.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Grant watchdog: 8-bit saturating cycle counter that flags a grant
// which has waited TIMEOUT cycles for RAM completion.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + 8'd1;
        end
    end

    // Fires during the TIMEOUT-th waiting cycle so the FSM leaves on that edge.
    assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data access for the
// single shared RAM port, with sticky fault on RAM error or watchdog expiry.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    import cpu_types_pkg::*;

    arb_state_t state, state_nxt;
    arb_chan_t  last, last_nxt;

    logic dreq, ireq, access, ramerr, grant, expired;

    assign dreq   = bus.dREN | bus.dWEN;
    assign ireq   = bus.iREN;
    assign access = (bus.ramstate == ACCESS);
    assign ramerr = (bus.ramstate == ERROR);
    assign grant  = (state == DGRANT) || (state == IGRANT);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (!grant),
        .enable  (grant && !access),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            last  <= INSTR;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (dreq && ireq)
                    state_nxt = (last == INSTR) ? DGRANT : IGRANT;
                else if (dreq)
                    state_nxt = DGRANT;
                else if (ireq)
                    state_nxt = IGRANT;
            end
            DGRANT: begin
                if (ramerr) begin
                    state_nxt = FAULT;
                end else if (!dreq) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    state_nxt = IDLE;
                    last_nxt  = DATA;
                end else if (expired) begin
                    state_nxt = FAULT;
                end
            end
            IGRANT: begin
                if (ramerr) begin
                    state_nxt = FAULT;
                end else if (!ireq) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    state_nxt = IDLE;
                    last_nxt  = INSTR;
                end else if (expired) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.iload    = '0;
        bus.dhit     = 1'b0;
        bus.dload    = '0;
        bus.err      = (state == FAULT);
        case (state)
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (access && dreq) begin
                    bus.dhit  = 1'b1;
                    bus.dload = bus.ramload;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (access && ireq) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a short watchdog (TIMEOUT=4).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   nvec;
    int   nerr;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus fully quiet: no enables, no address, no hits.
    task automatic chk_quiet(input string tag);
        chk({tag, ".ramREN"},  32'(bus.ramREN),  32'd0);
        chk({tag, ".ramWEN"},  32'(bus.ramWEN),  32'd0);
        chk({tag, ".ramaddr"}, bus.ramaddr,      32'd0);
        chk({tag, ".ihit"},    32'(bus.ihit),    32'd0);
        chk({tag, ".iload"},   bus.iload,        32'd0);
        chk({tag, ".dhit"},    32'(bus.dhit),    32'd0);
        chk({tag, ".dload"},   bus.dload,        32'd0);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic edge_;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        nRST = 1'b0;
        bus.iREN = 1'b1;  bus.iaddr = 32'h40;
        bus.dREN = 1'b0;  bus.dWEN = 1'b0;
        bus.daddr = '0;   bus.dstore = '0;
        bus.ramload = 32'h11223344;
        bus.ramstate = ACCESS;

        // Reset held with a pending request and ACCESS showing
        repeat (2) @(posedge CLK);
        #4;
        chk_quiet("rst");
        chk("rst.err", 32'(bus.err), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        edge_; #3;
        chk("rst.igrant.ramREN", 32'(bus.ramREN), 32'd1);
        chk("rst.igrant.ramaddr", bus.ramaddr, 32'h40);
        chk("rst.igrant.ihit", 32'(bus.ihit), 32'd1);
        chk("rst.igrant.iload", bus.iload, 32'h11223344);
        chk("rst.igrant.dhit", 32'(bus.dhit), 32'd0);
        edge_;
        bus.iREN = 1'b0;
        #3;
        chk_quiet("rst.idle");

        // Lone data read: two BUSY cycles then ACCESS
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        bus.ramstate = BUSY; bus.ramload = 32'hDEADBEEF;
        for (int c = 1; c <= 2; c++) begin
            edge_; #3;
            chk("rd.busy.ramREN", 32'(bus.ramREN), 32'd1);
            chk("rd.busy.ramaddr", bus.ramaddr, 32'h100);
            chk("rd.busy.dhit", 32'(bus.dhit), 32'd0);
        end
        edge_;
        bus.ramstate = ACCESS;
        #3;
        chk("rd.acc.ramREN", 32'(bus.ramREN), 32'd1);
        chk("rd.acc.ramaddr", bus.ramaddr, 32'h100);
        chk("rd.acc.dhit", 32'(bus.dhit), 32'd1);
        chk("rd.acc.dload", bus.dload, 32'hDEADBEEF);
        chk("rd.acc.ihit", 32'(bus.ihit), 32'd0);
        edge_;
        bus.dREN = 1'b0; bus.ramstate = FREE;
        #3;
        chk_quiet("rd.idle");

        // Contention from reset: data first, then alternation
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'hCAFEF00D;
        bus.ramload = 32'h55AA55AA; bus.ramstate = ACCESS;
        #1;
        chk_quiet("ct.rst");
        @(negedge CLK);
        nRST = 1'b1;
        edge_; #3;
        chk("ct.d1.ramWEN", 32'(bus.ramWEN), 32'd1);
        chk("ct.d1.ramREN", 32'(bus.ramREN), 32'd0);
        chk("ct.d1.ramaddr", bus.ramaddr, 32'h300);
        chk("ct.d1.ramstore", bus.ramstore, 32'hCAFEF00D);
        chk("ct.d1.dhit", 32'(bus.dhit), 32'd1);
        chk("ct.d1.dload", bus.dload, 32'h55AA55AA);
        chk("ct.d1.ihit", 32'(bus.ihit), 32'd0);
        edge_; #3;
        chk_quiet("ct.turn1");
        edge_; #3;
        chk("ct.i1.ramREN", 32'(bus.ramREN), 32'd1);
        chk("ct.i1.ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("ct.i1.ramaddr", bus.ramaddr, 32'h200);
        chk("ct.i1.ramstore", bus.ramstore, 32'd0);
        chk("ct.i1.ihit", 32'(bus.ihit), 32'd1);
        chk("ct.i1.iload", bus.iload, 32'h55AA55AA);
        chk("ct.i1.dhit", 32'(bus.dhit), 32'd0);
        edge_; #3;
        chk_quiet("ct.turn2");
        edge_;
        bus.dREN = 1'b1;
        #3;
        chk("ct.d2.ramWEN", 32'(bus.ramWEN), 32'd1);
        chk("ct.d2.ramREN", 32'(bus.ramREN), 32'd0);
        chk("ct.d2.dhit", 32'(bus.dhit), 32'd1);
        chk("ct.d2.ihit", 32'(bus.ihit), 32'd0);
        edge_;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        #3;
        chk_quiet("ct.idle");

        // Abort: instruction request dropped before ACCESS
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
        edge_; #3;
        chk("ab.grant.ramREN", 32'(bus.ramREN), 32'd1);
        chk("ab.grant.ramaddr", bus.ramaddr, 32'h44);
        chk("ab.grant.ihit", 32'(bus.ihit), 32'd0);
        edge_;
        bus.iREN = 1'b0;
        bus.ramstate = ACCESS;
        #3;
        chk("ab.drop.ihit", 32'(bus.ihit), 32'd0);
        bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramload = 32'h0BADCAFE;
        edge_; #3;
        chk_quiet("ab.idle");
        edge_; #3;
        chk("ab.d.ramaddr", bus.ramaddr, 32'h500);
        chk("ab.d.ramREN", 32'(bus.ramREN), 32'd1);
        chk("ab.d.dhit", 32'(bus.dhit), 32'd1);
        chk("ab.d.dload", bus.dload, 32'h0BADCAFE);
        edge_;
        bus.dREN = 1'b0; bus.ramstate = BUSY;
        #3;
        chk_quiet("ab.end");

        // Reset asserted mid-grant: enables drop at once, no hit
        bus.dREN = 1'b1; bus.daddr = 32'h600;
        edge_; #3;
        chk("mr.grant.ramREN", 32'(bus.ramREN), 32'd1);
        nRST = 1'b0;
        bus.ramstate = ACCESS;
        #1;
        chk_quiet("mr.rst");
        @(negedge CLK);
        bus.dREN = 1'b0; bus.ramstate = BUSY;
        nRST = 1'b1;

        // Watchdog: RAM stuck BUSY for a data read
        edge_;
        bus.dREN = 1'b1; bus.daddr = 32'h700;
        for (int c = 1; c <= 4; c++) begin
            edge_; #3;
            chk("wd.wait.ramREN", 32'(bus.ramREN), 32'd1);
            chk("wd.wait.err", 32'(bus.err), 32'd0);
        end
        edge_; #3;
        chk_quiet("wd.fault");
        chk("wd.fault.err", 32'(bus.err), 32'd1);
        bus.ramstate = ACCESS; bus.iREN = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            edge_; #3;
            chk_quiet("wd.hold");
            chk("wd.hold.err", 32'(bus.err), 32'd1);
        end
        nRST = 1'b0;
        #1;
        chk("wd.rst.err", 32'(bus.err), 32'd0);
        @(negedge CLK);
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = BUSY;
        nRST = 1'b1;

        // RAM error while instruction fetch is granted
        edge_;
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        edge_;
        bus.ramstate = ERROR;
        #3;
        chk("re.grant.ramREN", 32'(bus.ramREN), 32'd1);
        chk("re.grant.ihit", 32'(bus.ihit), 32'd0);
        chk("re.grant.err", 32'(bus.err), 32'd0);
        edge_; #3;
        chk_quiet("re.fault");
        chk("re.fault.err", 32'(bus.err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the request unit's instruction-fetch and data-access channels and the one shared RAM port. Grants one channel at a time with round-robin fairness, forwards RAM completion back as `ihit`/`dhit`, and raises a sticky error on RAM fault or watchdog timeout. Sits between the request unit (`iREN`/`dREN`/`dWEN`) and the RAM model.

## Interface
Parameters:
- `TIMEOUT`, 64: max cycles a grant may wait for `ACCESS` before error; legal 2..255.

Ports:
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `iREN`  in  1  instruction read request, held until `ihit`
- `iaddr`  in  32  instruction address (`word_t`)
- `ihit`  out  1  instruction access complete this cycle
- `iload`  out  32  instruction data, valid when `ihit`
- `dREN`  in  1  data read request, held until `dhit`
- `dWEN`  in  1  data write request, held until `dhit`
- `daddr`  in  32  data address
- `dstore`  in  32  data write value
- `dhit`  out  1  data access complete this cycle
- `dload`  out  32  data read value, valid when `dhit` on a read
- `ramREN`  out  1  RAM read enable
- `ramWEN`  out  1  RAM write enable
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  `ramstate_t`: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- `err`  out  1  sticky fault flag

## Operation
- States: IDLE, DGRANT, IGRANT, FAULT. `last` bit records the most recently completed channel (reset = INSTR).
- IDLE: data pending (`dREN|dWEN`) and instr pending → grant the channel ≠ `last`. Only one pending → grant it. None → stay.
- DGRANT: `ramWEN=dWEN`, `ramREN=dREN & ~dWEN` (write wins if both asserted), `ramaddr=daddr`, `ramstore=dstore`.
- IGRANT: `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`, `ramstore=0`.
- IDLE/FAULT: all `ram*` outputs 0.
- Completion: in DGRANT with `ramstate==ACCESS` and request still high → `dhit=1`, `dload=ramload`. Next state IDLE, `last`←DATA. IGRANT analogous with `ihit`/`iload`, `last`←INSTR.
- Abort: requester drops its request while granted, before ACCESS → next state IDLE, no hit, `last` unchanged.
- `ramstate==ERROR` in any grant state → FAULT, `err`←1.
- Watchdog: cycle counter cleared on entering a grant state, increments each grant cycle without ACCESS. Reaching `TIMEOUT` → FAULT, `err`←1.
- FAULT is terminal until `nRST`. No hits and no RAM enables in FAULT.
- `ihit` and `dhit` are never both 1. Hits are asserted only in grant states.
- `iload`/`dload` are 0 when their hit is low.

## Timing
- Reset (async, `nRST=0`): state IDLE, `last`=INSTR, counter 0, `err`=0. All outputs 0 immediately.
- Request sampled in IDLE at edge N → grant state and RAM enables from cycle N+1.
- Hit is combinational in the same cycle `ramstate` shows ACCESS. Minimum request-to-hit = 1 cycle after the request cycle.
- Return to IDLE after each hit: exactly one IDLE bus-turnaround cycle between back-to-back grants.
- Requests arriving during a grant wait for IDLE; they are not queued.
- Reset asserted mid-grant: RAM enables drop asynchronously, no hit issued.

## Structure
- `cpu_types_pkg`: `word_t`, `ramstate_t` (existing). Add `arb_state_t` (IDLE, DGRANT, IGRANT, FAULT) and `arb_chan_t` (INSTR, DATA) here.
- One sub-module: `arb_watchdog` (clear, enable, `TIMEOUT` parameter, `expired` output), 8-bit saturating counter.
- Top module holds the FSM register, the `last` register, and the combinational output mux.

## Test plan
- Reset: `nRST` low with `iREN=1` and `ramstate=ACCESS` → all outputs 0, `err=0`. After release, IGRANT the next cycle.
- Lone read: `dREN=1`, `daddr=0x100`, RAM ACCESS after 2 BUSY cycles with `ramload=0xDEADBEEF` → `ramREN=1` and `ramaddr=0x100` for 3 cycles. `dhit=1` and `dload=0xDEADBEEF` on the third. IDLE next cycle.
- Contention: `iREN`, `dWEN` both held from reset (`last`=INSTR) → DGRANT first (`ramWEN=1`, `ramstore=dstore`). After `dhit`, one IDLE cycle, then IGRANT → `ihit`. Alternation continues with both held.
- Abort: `iREN` dropped in IGRANT before ACCESS → IDLE next cycle, no `ihit`. A subsequent `dREN` is granted normally.
- Watchdog: `TIMEOUT=4`, `dREN=1`, `ramstate` stuck at BUSY → FAULT after 4 grant cycles, `err=1`. RAM enables 0 and `err` held until `nRST`.
- RAM error: `ramstate=ERROR` during IGRANT → no `ihit`, FAULT next cycle, `err=1`.
